// File: rtl/mem_writein_demux.sv
// Splits the merged readout stream by destination tag into NDEST paged memories and reports per-BX item counts.
// Latency: one clk from an input word or header to wr_en / counts_valid.
// Backpressure: none; accepts one word per clk, and words that cannot be stored are dropped and flagged.
module mem_writein_demux #(
    parameter int NDEST  = 16,
    parameter int ADDR_W = 6,
    parameter int PAGE_W = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [54:0]               mem_dat_stream,
    input  logic                      valid,
    input  logic                      send_BX,
    output logic [NDEST-1:0]          wr_en,
    output logic [PAGE_W+ADDR_W-1:0]  wr_addr,
    output logic [50:0]               wr_dat,
    output logic [NDEST*ADDR_W-1:0]   number_out,
    output logic                      counts_valid,
    output logic [2:0]                counts_BX,
    output logic [2:0]                cur_BX,
    output logic [NDEST-1:0]          overflow,
    output logic                      proto_err
);

    localparam logic [0:0]        ST_IDLE = 1'b0;
    localparam logic [0:0]        ST_RUN  = 1'b1;
    // A page holds 2**ADDR_W-1 items, so an all-ones count means the page is full.
    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    logic [0:0]               state_q, state_d;
    logic [ADDR_W-1:0]        cnt_q [NDEST];
    logic [ADDR_W-1:0]        cnt_d [NDEST];
    logic [2:0]               cur_bx_q, cur_bx_d;
    logic [NDEST-1:0]         wr_en_q, wr_en_d;
    logic [PAGE_W+ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [50:0]              wr_dat_q, wr_dat_d;
    logic [NDEST*ADDR_W-1:0]  number_out_q, number_out_d;
    logic                     counts_valid_q, counts_valid_d;
    logic [2:0]               counts_bx_q, counts_bx_d;
    logic [NDEST-1:0]         overflow_q, overflow_d;
    logic                     proto_err_q, proto_err_d;

    logic [3:0]               tag;
    logic [50:0]              payload;
    logic                     tag_ok;

    assign tag     = mem_dat_stream[54:51];
    assign payload = mem_dat_stream[50:0];
    assign tag_ok  = (32'(tag) < NDEST);

    // Next-state: headers close the current BX, data words are steered to their destination page.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cur_bx_d       = cur_bx_q;
        wr_en_d        = '0;
        wr_addr_d      = wr_addr_q;
        wr_dat_d       = wr_dat_q;
        number_out_d   = number_out_q;
        counts_valid_d = 1'b0;
        counts_bx_d    = counts_bx_q;
        overflow_d     = overflow_q;
        proto_err_d    = proto_err_q;

        if (send_BX) begin
            // A header wins over a simultaneous data word; that word is lost.
            if (valid) begin
                proto_err_d = 1'b1;
            end
            // Only a header that ends a running BX has counts worth publishing.
            if (state_q == ST_RUN) begin
                for (int i = 0; i < NDEST; i++) begin
                    number_out_d[i*ADDR_W +: ADDR_W] = cnt_q[i];
                    cnt_d[i]                         = '0;
                end
                counts_bx_d    = cur_bx_q;
                counts_valid_d = 1'b1;
            end
            cur_bx_d = mem_dat_stream[2:0];
            state_d  = ST_RUN;
        end else if (valid) begin
            if (state_q == ST_IDLE || !tag_ok) begin
                proto_err_d = 1'b1;
            end else begin
                for (int i = 0; i < NDEST; i++) begin
                    if (tag == 4'(i)) begin
                        if (cnt_q[i] == CNT_MAX) begin
                            overflow_d[i] = 1'b1;
                        end else begin
                            wr_en_d[i] = 1'b1;
                            wr_addr_d  = {cur_bx_q[PAGE_W-1:0], cnt_q[i]};
                            wr_dat_d   = payload;
                            cnt_d[i]   = cnt_q[i] + 1'b1;
                        end
                    end
                end
            end
        end
    end

    // State and output registers; everything clears on the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            for (int i = 0; i < NDEST; i++) begin
                cnt_q[i] <= '0;
            end
            cur_bx_q       <= '0;
            wr_en_q        <= '0;
            wr_addr_q      <= '0;
            wr_dat_q       <= '0;
            number_out_q   <= '0;
            counts_valid_q <= 1'b0;
            counts_bx_q    <= '0;
            overflow_q     <= '0;
            proto_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            cur_bx_q       <= cur_bx_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_dat_q       <= wr_dat_d;
            number_out_q   <= number_out_d;
            counts_valid_q <= counts_valid_d;
            counts_bx_q    <= counts_bx_d;
            overflow_q     <= overflow_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_dat       = wr_dat_q;
    assign number_out   = number_out_q;
    assign counts_valid = counts_valid_q;
    assign counts_BX    = counts_bx_q;
    assign cur_BX       = cur_bx_q;
    assign overflow     = overflow_q;
    assign proto_err    = proto_err_q;

endmodule
